// File: rtl/rle_acici_pkg.sv
// Types and widths shared by the run-length expander and its amplitude extender.
`include "sabitler.vh"

package rle_acici_pkg;

    localparam int RUN_W     = `RUN_BIT;
    localparam int CAT_W     = `CAT_BIT;
    localparam int GENLIK_W  = `GENLIK_BIT;
    localparam int KATSAYI_W = `KATSAYI_BIT;
    localparam int IDX_W     = 6;
    localparam int SIFIR_W   = 5;

    localparam logic [RUN_W-1:0]   EOB_RUN   = `EOB_RUN;
    localparam logic [CAT_W-1:0]   EOB_CAT   = `EOB_CAT;
    localparam logic [RUN_W-1:0]   ZRL_RUN   = `ZRL_RUN;
    localparam logic [CAT_W-1:0]   ZRL_CAT   = `ZRL_CAT;
    localparam logic [SIFIR_W-1:0] ZRL_SIFIR = `ZRL_SIFIR;
    localparam logic [IDX_W-1:0]   SON_IDX   = 6'd63;

    typedef enum logic [2:0] {
        DC_BEKLE,
        AC_BEKLE,
        SIFIR_YAZ,
        KATSAYI_YAZ,
        DOLDUR
    } durum_t;

endpackage

// File: rtl/rle_acici_genlik_genislet.sv
// Combinational JPEG EXTEND: turns a category plus raw amplitude bits into a signed coefficient.
module genlik_genislet
    import rle_acici_pkg::*;
(
    input  logic [CAT_W-1:0]     cat_i,
    input  logic [GENLIK_W-1:0]  genlik_i,
    output logic [KATSAYI_W-1:0] deger_o
);

    localparam int GW = KATSAYI_W + 1;

    logic [CAT_W-1:0]    cat_eff;
    logic [GW-1:0]       agirlik;
    logic [GENLIK_W-1:0] maske;
    logic [GENLIK_W-1:0] bitler;
    logic                pozitif;

    always_comb begin
        // Categories above the amplitude width cannot occur legally; clamp so the shift stays bounded.
        cat_eff = (cat_i > CAT_W'(GENLIK_W)) ? CAT_W'(GENLIK_W) : cat_i;
        agirlik = GW'(1) << cat_eff;
        maske   = GENLIK_W'(agirlik - GW'(1));
        bitler  = genlik_i & maske;
        pozitif = |(bitler & (maske ^ (maske >> 1)));
        if (cat_eff == '0) begin
            deger_o = '0;
        end else if (pozitif) begin
            deger_o = KATSAYI_W'(bitler);
        end else begin
            deger_o = KATSAYI_W'(GW'(bitler) - agirlik + GW'(1));
        end
    end

endmodule

// File: rtl/sabitler.vh
// Shared field widths and special AC symbol codes of the JPEG entropy path.
`ifndef SABITLER_VH
`define SABITLER_VH

`define RUN_BIT      4
`define CAT_BIT      4
`define GENLIK_BIT   11
`define KATSAYI_BIT  12

`define EOB_RUN      4'd0
`define EOB_CAT      4'd0
`define ZRL_RUN      4'd15
`define ZRL_CAT      4'd0
`define ZRL_SIFIR    5'd16

`endif

// File: rtl/rle_acici.sv
// Run-length expander: decoded (run, cat, amplitude) symbols in, 64 zigzag coefficients per block out.
module rle_acici
    import rle_acici_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic [RUN_W-1:0]     hd_run_i,
    input  logic [CAT_W-1:0]     hd_cat_i,
    input  logic [GENLIK_W-1:0]  hd_genlik_i,
    input  logic                 hd_gecerli_i,
    output logic                 hd_hazir_o,
    input  logic                 dc_sifirla_i,
    output logic [KATSAYI_W-1:0] ks_veri_o,
    output logic [IDX_W-1:0]     ks_indeks_o,
    output logic                 ks_gecerli_o,
    input  logic                 ks_hazir_i,
    output logic                 ks_blok_son_o,
    output logic                 hata_o,
    output logic [2:0]           durum_o
);

    // Handshakes: a beat/symbol moves on a rising edge where valid && ready; valid never waits on ready.
    durum_t               durum_q, sonraki;
    logic [KATSAYI_W-1:0] pred_q, katsayi_q;
    logic [IDX_W-1:0]     idx_q;
    logic [SIFIR_W-1:0]   sifir_q;
    logic                 kats_bekle_q;
    logic [KATSAYI_W-1:0] ks_veri_q;
    logic [IDX_W-1:0]     ks_indeks_q;
    logic                 ks_gecerli_q, ks_son_q, hata_q;

    logic [KATSAYI_W-1:0] ext_deger, pred_eff, dc_deger;
    logic                 cikis_bos, kabul;
    logic                 eob, zrl;
    logic [SIFIR_W-1:0]   plan_sifir;
    logic                 atim, sifir_atimi, son_atim, tasma;
    logic [SIFIR_W-1:0]   kaynak_sifir, kalan_sifir;
    logic                 kaynak_kats, kaynak_doldur, kalan_kats;
    logic [KATSAYI_W-1:0] kaynak_deger, atim_veri;

    genlik_genislet u_genislet (
        .cat_i    (hd_cat_i),
        .genlik_i (hd_genlik_i),
        .deger_o  (ext_deger)
    );

    assign cikis_bos  = !ks_gecerli_q || ks_hazir_i;
    assign hd_hazir_o = !rstn_i && cikis_bos && (durum_q == DC_BEKLE || durum_q == AC_BEKLE);
    assign kabul      = hd_gecerli_i && hd_hazir_o;
    assign pred_eff   = dc_sifirla_i ? '0 : pred_q;
    assign dc_deger   = pred_eff + ext_deger;

    assign eob = (hd_run_i == EOB_RUN) && (hd_cat_i == EOB_CAT);
    assign zrl = (hd_run_i == ZRL_RUN) && (hd_cat_i == ZRL_CAT);

    always_comb begin
        if (zrl) begin
            plan_sifir = ZRL_SIFIR;
        end else if (hd_cat_i == '0) begin
            plan_sifir = {1'b0, hd_run_i} + SIFIR_W'(1);
        end else begin
            plan_sifir = SIFIR_W'(hd_run_i);
        end
    end

    // Every AC-side beat comes from one source descriptor: zeros still owed, a pending coefficient, or fill-to-end.
    always_comb begin
        atim          = 1'b0;
        kaynak_sifir  = '0;
        kaynak_kats   = 1'b0;
        kaynak_doldur = 1'b0;
        kaynak_deger  = katsayi_q;
        case (durum_q)
            AC_BEKLE: if (kabul) begin
                atim          = 1'b1;
                kaynak_sifir  = eob ? '0 : plan_sifir;
                kaynak_kats   = (hd_cat_i != '0);
                kaynak_doldur = eob;
                kaynak_deger  = ext_deger;
            end
            SIFIR_YAZ: if (cikis_bos) begin
                atim         = 1'b1;
                kaynak_sifir = sifir_q;
                kaynak_kats  = kats_bekle_q;
            end
            KATSAYI_YAZ: if (cikis_bos) begin
                atim        = 1'b1;
                kaynak_kats = 1'b1;
            end
            DOLDUR: if (cikis_bos) begin
                atim          = 1'b1;
                kaynak_doldur = 1'b1;
            end
            default: ;
        endcase

        sifir_atimi = kaynak_doldur || (kaynak_sifir != '0);
        atim_veri   = sifir_atimi ? '0 : kaynak_deger;
        kalan_sifir = (kaynak_sifir != '0) ? kaynak_sifir - SIFIR_W'(1) : '0;
        kalan_kats  = sifir_atimi && kaynak_kats;
        son_atim    = (idx_q == SON_IDX);
        // Anything still owed when index 63 goes out would land past the block.
        tasma       = son_atim && !kaynak_doldur && ((kalan_sifir != '0) || kalan_kats);

        if (son_atim)                 sonraki = DC_BEKLE;
        else if (kaynak_doldur)       sonraki = DOLDUR;
        else if (kalan_sifir != '0)   sonraki = SIFIR_YAZ;
        else if (kalan_kats)          sonraki = KATSAYI_YAZ;
        else                          sonraki = AC_BEKLE;
    end

    always_ff @(posedge clk_i) begin
        if (rstn_i) begin
            durum_q      <= DC_BEKLE;
            pred_q       <= '0;
            katsayi_q    <= '0;
            idx_q        <= '0;
            sifir_q      <= '0;
            kats_bekle_q <= 1'b0;
            ks_veri_q    <= '0;
            ks_indeks_q  <= '0;
            ks_gecerli_q <= 1'b0;
            ks_son_q     <= 1'b0;
            hata_q       <= 1'b0;
        end else begin
            if (cikis_bos) begin
                ks_gecerli_q <= 1'b0;
            end
            if (dc_sifirla_i) begin
                pred_q <= '0;
            end
            if (durum_q == DC_BEKLE && kabul) begin
                pred_q       <= dc_deger;
                ks_veri_q    <= dc_deger;
                ks_indeks_q  <= '0;
                ks_son_q     <= 1'b0;
                ks_gecerli_q <= 1'b1;
                idx_q        <= IDX_W'(1);
                durum_q      <= AC_BEKLE;
            end else if (atim) begin
                ks_veri_q    <= atim_veri;
                ks_indeks_q  <= idx_q;
                ks_son_q     <= son_atim;
                ks_gecerli_q <= 1'b1;
                idx_q        <= son_atim ? '0 : idx_q + IDX_W'(1);
                sifir_q      <= kalan_sifir;
                kats_bekle_q <= kalan_kats;
                if (durum_q == AC_BEKLE) begin
                    katsayi_q <= ext_deger;
                end
                if (tasma) begin
                    hata_q <= 1'b1;
                end
                durum_q <= sonraki;
            end
        end
    end

    assign ks_veri_o     = ks_veri_q;
    assign ks_indeks_o   = ks_indeks_q;
    assign ks_gecerli_o  = ks_gecerli_q;
    assign ks_blok_son_o = ks_son_q;
    assign hata_o        = hata_q;
    assign durum_o       = durum_q;

endmodule

// File: tb/tb_rle_acici.sv
// Bench for rle_acici: DC vector table, hand-written block sequences, and a beat scoreboard.
module tb_rle_acici;
    import rle_acici_pkg::*;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic [3:0]  hd_run_i, hd_cat_i;
    logic [10:0] hd_genlik_i;
    logic        hd_gecerli_i, hd_hazir_o, dc_sifirla_i;
    logic [11:0] ks_veri_o;
    logic [5:0]  ks_indeks_o;
    logic        ks_gecerli_o, ks_hazir_i, ks_blok_son_o, hata_o;
    logic [2:0]  durum_o;

    always #5 clk_i = ~clk_i;

    rle_acici dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .hd_run_i      (hd_run_i),
        .hd_cat_i      (hd_cat_i),
        .hd_genlik_i   (hd_genlik_i),
        .hd_gecerli_i  (hd_gecerli_i),
        .hd_hazir_o    (hd_hazir_o),
        .dc_sifirla_i  (dc_sifirla_i),
        .ks_veri_o     (ks_veri_o),
        .ks_indeks_o   (ks_indeks_o),
        .ks_gecerli_o  (ks_gecerli_o),
        .ks_hazir_i    (ks_hazir_i),
        .ks_blok_son_o (ks_blok_son_o),
        .hata_o        (hata_o),
        .durum_o       (durum_o)
    );

    typedef struct {
        logic [3:0]  cat;
        logic [10:0] genlik;
        logic        clr;
        logic [11:0] exp_dc;
    } dc_vec_t;

    dc_vec_t     vecs[10];
    logic [18:0] exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    logic signed [11:0] m_pred;
    int                 m_idx;
    bit                 m_in_ac;
    bit                 m_hata;

    int          hazir_mod = 0;
    logic [11:0] last_dc = '0;
    bit          stall = 1'b0;
    logic [18:0] stall_beat;

    function automatic logic [11:0] ref_ext(input logic [3:0] cat, input logic [10:0] g);
        int c, v;
        c = (cat > 4'd11) ? 11 : int'(cat);
        if (c == 0) return 12'd0;
        v = int'(g) % (1 << c);
        if (v >= (1 << (c - 1))) return 12'(v);
        return 12'(v - (1 << c) + 1);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic push_beat(input logic [11:0] d);
        exp_q.push_back({d, 6'(m_idx), (m_idx == 63)});
        m_idx++;
    endtask

    task automatic model_accept(input logic [3:0] run, input logic [3:0] cat,
                                input logic [10:0] g, input logic clr);
        int nz;
        if (clr) m_pred = '0;
        if (!m_in_ac) begin
            m_pred  = m_pred + signed'(ref_ext(cat, g));
            m_idx   = 0;
            push_beat(m_pred);
            m_in_ac = 1'b1;
        end else begin
            if (cat == 0 && run == 0)  nz = 64 - m_idx;
            else if (cat == 0 && run == 15) nz = 16;
            else if (cat == 0)         nz = int'(run) + 1;
            else                       nz = int'(run);
            for (int i = 0; i < nz; i++) begin
                if (m_idx == 64) begin
                    m_hata = 1'b1;
                    break;
                end
                push_beat(12'd0);
            end
            if (cat != 0) begin
                if (m_idx == 64) m_hata = 1'b1;
                else push_beat(ref_ext(cat, g));
            end
            if (m_idx == 64) begin
                m_in_ac = 1'b0;
                m_idx   = 0;
            end
        end
    endtask

    // Called and returns one time unit after a rising edge.
    task automatic send_sym(input logic [3:0] run, input logic [3:0] cat,
                            input logic [10:0] g, input logic clr);
        bit acc = 1'b0;
        int waited = 0;
        hd_run_i     = run;
        hd_cat_i     = cat;
        hd_genlik_i  = g;
        dc_sifirla_i = clr;
        hd_gecerli_i = 1'b1;
        while (!acc && waited < 2000) begin
            @(negedge clk_i);
            if (hd_hazir_o) begin
                model_accept(run, cat, g, clr);
                acc = 1'b1;
            end
            @(posedge clk_i);
            #1;
            waited++;
        end
        hd_gecerli_i = 1'b0;
        dc_sifirla_i = 1'b0;
        if (!acc) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: run=%0d cat=%0d not accepted, expected accept", run, cat);
        end
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk_i);
            if (exp_q.size() == 0 && !ks_gecerli_o) done = 1'b1;
            @(posedge clk_i);
            #1;
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: %0d beats outstanding, expected 0", exp_q.size());
        end
    endtask

    initial begin
        ks_hazir_i = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            case (hazir_mod)
                0:       ks_hazir_i = 1'b1;
                1:       ks_hazir_i = ~ks_hazir_i;
                default: ks_hazir_i = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    always @(negedge clk_i) begin
        if (rstn_i) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                n_vec++;
                if (!ks_gecerli_o || {ks_veri_o, ks_indeks_o, ks_blok_son_o} !== stall_beat) begin
                    n_err++;
                    $display("FAIL hold: got v=%0b %h, expected held %h",
                             ks_gecerli_o, {ks_veri_o, ks_indeks_o, ks_blok_son_o}, stall_beat);
                end
            end
            if (ks_gecerli_o && ks_hazir_i) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL beat: got idx=%0d data=0x%0h, expected no beat", ks_indeks_o, ks_veri_o);
                end else begin
                    logic [18:0] e;
                    e = exp_q.pop_front();
                    if ({ks_veri_o, ks_indeks_o, ks_blok_son_o} !== e) begin
                        n_err++;
                        $display("FAIL beat: got data=0x%0h idx=%0d son=%0b, expected data=0x%0h idx=%0d son=%0b",
                                 ks_veri_o, ks_indeks_o, ks_blok_son_o, e[18:7], e[6:1], e[0]);
                    end
                    if (ks_indeks_o == 6'd0) last_dc = ks_veri_o;
                end
            end
            stall      = ks_gecerli_o && !ks_hazir_i;
            stall_beat = {ks_veri_o, ks_indeks_o, ks_blok_son_o};
        end
    end

    initial begin
        bit found;
        vecs[0] = '{4'd3,  11'h002, 1'b0, 12'hFFB};
        vecs[1] = '{4'd2,  11'h003, 1'b0, 12'hFFE};
        vecs[2] = '{4'd1,  11'h001, 1'b1, 12'h001};
        vecs[3] = '{4'd0,  11'h7FF, 1'b1, 12'h000};
        vecs[4] = '{4'd11, 11'h400, 1'b1, 12'h400};
        vecs[5] = '{4'd11, 11'h3FF, 1'b1, 12'hC00};
        vecs[6] = '{4'd11, 11'h7FF, 1'b1, 12'h7FF};
        vecs[7] = '{4'd11, 11'h7FF, 1'b0, 12'hFFE};
        vecs[8] = '{4'd4,  11'h7F5, 1'b1, 12'hFF6};
        vecs[9] = '{4'd5,  11'h010, 1'b0, 12'h006};

        m_pred = '0; m_idx = 0; m_in_ac = 1'b0; m_hata = 1'b0;
        rstn_i = 1'b1; hd_run_i = '0; hd_cat_i = '0; hd_genlik_i = '0;
        hd_gecerli_i = 1'b1; dc_sifirla_i = 1'b0;

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_hd_hazir", 32'(hd_hazir_o), 32'd0);
        chk("rst_gecerli", 32'(ks_gecerli_o), 32'd0);
        chk("rst_veri", 32'(ks_veri_o), 32'd0);
        chk("rst_indeks", 32'(ks_indeks_o), 32'd0);
        chk("rst_blok_son", 32'(ks_blok_son_o), 32'd0);
        chk("rst_hata", 32'(hata_o), 32'd0);
        hd_gecerli_i = 1'b0;
        rstn_i = 1'b0;
        @(posedge clk_i);
        #1;

        foreach (vecs[i]) begin
            send_sym(4'd0, vecs[i].cat, vecs[i].genlik, vecs[i].clr);
            send_sym(4'd0, 4'd0, 11'd0, 1'b0);
            wait_drain();
            chk($sformatf("dc_row%0d", i), 32'(last_dc), 32'(vecs[i].exp_dc));
        end
        chk("hata_after_table", 32'(hata_o), 32'd0);

        hazir_mod = 1;
        send_sym(4'd0, 4'd2, 11'h003, 1'b0);
        send_sym(4'd2, 4'd1, 11'h000, 1'b0);
        send_sym(4'd0, 4'd0, 11'd0, 1'b0);
        wait_drain();

        // Block closed by a coefficient at 63 with no EOB; the next symbol must be taken as DC.
        hazir_mod = 2;
        send_sym(4'd0, 4'd1, 11'h000, 1'b0);
        send_sym(4'd5, 4'd0, 11'h000, 1'b0);
        repeat (3) send_sym(4'd15, 4'd0, 11'h000, 1'b0);
        send_sym(4'd8, 4'd3, 11'h005, 1'b0);
        send_sym(4'd0, 4'd1, 11'h001, 1'b0);
        send_sym(4'd0, 4'd0, 11'd0, 1'b0);
        wait_drain();
        chk("hata_exact_end", 32'(hata_o), 32'd0);

        hazir_mod = 0;
        dc_sifirla_i = 1'b1;
        m_pred = '0;
        @(posedge clk_i);
        #1;
        dc_sifirla_i = 1'b0;
        send_sym(4'd0, 4'd1, 11'h001, 1'b0);
        send_sym(4'd0, 4'd0, 11'd0, 1'b0);
        wait_drain();
        chk("dc_after_clear", 32'(last_dc), 32'h001);

        send_sym(4'd0, 4'd1, 11'h001, 1'b0);
        repeat (4) send_sym(4'd15, 4'd0, 11'h000, 1'b0);
        send_sym(4'd15, 4'd1, 11'h001, 1'b0);
        send_sym(4'd0, 4'd0, 11'd0, 1'b0);
        wait_drain();
        chk("hata_overflow", 32'(hata_o), 32'd1);

        hazir_mod = 2;
        for (int b = 0; b < 6; b++) begin
            send_sym(4'd0, 4'($urandom_range(0, 5)), 11'($urandom_range(0, 2047)), 1'($urandom_range(0, 1)));
            for (int s = 0; s < 20 && m_in_ac; s++) begin
                send_sym(4'($urandom_range(0, 6)), 4'($urandom_range(0, 6)),
                         11'($urandom_range(0, 2047)), 1'b0);
            end
            if (m_in_ac) send_sym(4'd0, 4'd0, 11'd0, 1'b0);
            wait_drain();
            chk($sformatf("hata_rand%0d", b), 32'(hata_o), 32'(m_hata));
        end

        hazir_mod = 0;
        send_sym(4'd0, 4'd1, 11'h001, 1'b0);
        send_sym(4'd0, 4'd0, 11'd0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk_i);
            if (ks_gecerli_o && ks_indeks_o == 6'd10) found = 1'b1;
            @(posedge clk_i);
            #1;
        end
        chk("mid_block_idx10_seen", 32'(found), 32'd1);
        rstn_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        chk("midrst_gecerli", 32'(ks_gecerli_o), 32'd0);
        chk("midrst_hd_hazir", 32'(hd_hazir_o), 32'd0);
        chk("midrst_indeks", 32'(ks_indeks_o), 32'd0);
        chk("midrst_hata", 32'(hata_o), 32'd0);
        exp_q.delete();
        m_pred = '0; m_idx = 0; m_in_ac = 1'b0; m_hata = 1'b0;
        @(posedge clk_i);
        #1;
        rstn_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        send_sym(4'd0, 4'd2, 11'h001, 1'b0);
        send_sym(4'd0, 4'd0, 11'd0, 1'b0);
        wait_drain();
        chk("post_reset_dc", 32'(last_dc), 32'hFFE);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
